// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART line monitor (receiver FSM states,
// parity modes, line-feed code, saturating counter increment).
package uart_mon_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    localparam logic [7:0] LF = 8'h0A;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Parity bit a transmitter would send for the given data byte.
    function automatic logic par_bit(input logic [7:0] d, input parity_e mode);
        case (mode)
            PAR_ODD:  return ~^d;
            PAR_EVEN: return ^d;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_mon_rx.sv
// Bit-level UART receiver: 2-flop input synchronizer, half-bit aligned sample
// timer and RX FSM; emits a one-cycle frame strobe with data and error flags.
module uart_mon_rx
    import uart_mon_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 434,
    parameter int      PAYLOAD_BITS = 8,
    parameter parity_e PAR_MODE     = PAR_NONE,
    parameter int      STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd_i,
    input  logic       rx_en_i,
    output logic       frm_vld_o,
    output logic [7:0] frm_data_o,
    output logic       frm_perr_o,
    output logic       frm_ferr_o,
    output logic       frm_brk_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rxd_s;
    logic          fall_s;
    logic          tick_s;
    logic          ferr_now_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          vld_q, vld_d;
    logic [7:0]    odata_q, odata_d;
    logic          operr_q, operr_d;
    logic          oferr_q, oferr_d;
    logic          obrk_q, obrk_d;

    assign rxd_s      = sync_q[1];
    assign fall_s     = prev_q & ~rxd_s;
    assign tick_s     = (cnt_q == {CW{1'b0}});
    assign ferr_now_s = ferr_q | ~rxd_s;

    assign frm_vld_o  = vld_q;
    assign frm_data_o = odata_q;
    assign frm_perr_o = operr_q;
    assign frm_ferr_o = oferr_q;
    assign frm_brk_o  = obrk_q;

    // Synchronizer, edge history and all FSM/datapath state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            vld_q   <= 1'b0;
            odata_q <= 8'h00;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
            obrk_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            prev_q  <= rxd_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            vld_q   <= vld_d;
            odata_q <= odata_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
            obrk_q  <= obrk_d;
        end
    end

    // Next-state logic; the frame verdict is produced at the final stop sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        vld_d   = 1'b0;
        odata_d = odata_q;
        operr_d = 1'b0;
        oferr_d = 1'b0;
        obrk_d  = 1'b0;
        if (!rx_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall_s) begin
                        state_d = START;
                        cnt_d   = CW'(CLKS_PER_BIT / 2);
                        bit_d   = 3'd0;
                        shreg_d = 8'h00;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (!tick_s) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!rxd_s) begin
                        state_d = DATA;
                        cnt_d   = CW'(CLKS_PER_BIT - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (!tick_s) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        shreg_d[bit_q] = rxd_s;
                        cnt_d          = CW'(CLKS_PER_BIT - 1);
                        if (bit_q == 3'(PAYLOAD_BITS - 1)) begin
                            bit_d   = 3'd0;
                            state_d = (PAR_MODE == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (!tick_s) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        perr_d  = (rxd_s != par_bit(shreg_q, PAR_MODE));
                        cnt_d   = CW'(CLKS_PER_BIT - 1);
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (!tick_s) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        ferr_d = ferr_now_s;
                        cnt_d  = CW'(CLKS_PER_BIT - 1);
                        if (bit_q == 3'(STOP_BITS - 1)) begin
                            state_d = IDLE;
                            vld_d   = 1'b1;
                            odata_d = shreg_q;
                            obrk_d  = ferr_now_s && (shreg_q == 8'h00);
                            oferr_d = ferr_now_s && (shreg_q != 8'h00);
                            operr_d = perr_q && !ferr_now_s;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_line_monitor.sv
// UART receive monitor top: line tagging, show-ahead character FIFO and
// saturating error counters. Define UART_LINE_MONITOR_LOG_EN for simulation line logging.
module uart_line_monitor #(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_LINE     = 128
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rxd,
    input  logic        uart_rx_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        rx_break,
    output logic [15:0] frame_err_cnt,
    output logic [15:0] parity_err_cnt,
    output logic [15:0] ovf_cnt
);
    import uart_mon_pkg::parity_e;
    import uart_mon_pkg::sat_inc16;
    import uart_mon_pkg::LF;

    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = (MAX_LINE > 2) ? $clog2(MAX_LINE) : 1;

    logic          frm_vld_s, frm_perr_s, frm_ferr_s, frm_brk_s;
    logic [7:0]    frm_data_s;
    logic          good_s, pop_s, push_s, drop_s, last_s, empty_s, full_s;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] line_q, line_d;
    logic [15:0]   ferr_cnt_q, ferr_cnt_d, perr_cnt_q, perr_cnt_d, ovf_cnt_q, ovf_cnt_d;

    uart_mon_rx #(
        .CLKS_PER_BIT (CPB),
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .PAR_MODE     (parity_e'(2'(PARITY))),
        .STOP_BITS    (STOP_BITS)
    ) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .rxd_i      (uart_rxd),
        .rx_en_i    (uart_rx_en),
        .frm_vld_o  (frm_vld_s),
        .frm_data_o (frm_data_s),
        .frm_perr_o (frm_perr_s),
        .frm_ferr_o (frm_ferr_s),
        .frm_brk_o  (frm_brk_s)
    );

    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign good_s  = frm_vld_s && !frm_perr_s && !frm_ferr_s && !frm_brk_s;
    assign pop_s   = !empty_s && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s  = good_s && (!full_s || pop_s);
    assign drop_s  = good_s && full_s && !pop_s;
    assign last_s  = (frm_data_s == LF) || (line_q == LW'(MAX_LINE - 1));

    assign out_valid            = !empty_s;
    assign {out_last, out_data} = empty_s ? 9'h000 : mem_q[rptr_q[AW-1:0]];
    assign rx_break             = frm_brk_s;
    assign frame_err_cnt        = ferr_cnt_q;
    assign parity_err_cnt       = perr_cnt_q;
    assign ovf_cnt              = ovf_cnt_q;

    // FIFO storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q[AW-1:0]] <= {last_s, frm_data_s};
        end
    end

    // Pointer, line counter and error counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q     <= {(AW+1){1'b0}};
            rptr_q     <= {(AW+1){1'b0}};
            line_q     <= {LW{1'b0}};
            ferr_cnt_q <= 16'h0000;
            perr_cnt_q <= 16'h0000;
            ovf_cnt_q  <= 16'h0000;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            line_q     <= line_d;
            ferr_cnt_q <= ferr_cnt_d;
            perr_cnt_q <= perr_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Next-state for pointers, line position and counters.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        line_d     = line_q;
        ferr_cnt_d = ferr_cnt_q;
        perr_cnt_d = perr_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (pop_s) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end else begin
            rptr_d = rptr_q;
        end
        if (push_s) begin
            wptr_d = wptr_q + (AW+1)'(1);
            line_d = last_s ? {LW{1'b0}} : line_q + LW'(1);
        end else begin
            wptr_d = wptr_q;
            line_d = line_q;
        end
        if (frm_vld_s && frm_ferr_s) begin
            ferr_cnt_d = sat_inc16(ferr_cnt_q);
        end else begin
            ferr_cnt_d = ferr_cnt_q;
        end
        if (frm_vld_s && frm_perr_s) begin
            perr_cnt_d = sat_inc16(perr_cnt_q);
        end else begin
            perr_cnt_d = perr_cnt_q;
        end
        if (drop_s) begin
            ovf_cnt_d = sat_inc16(ovf_cnt_q);
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

`ifdef UART_LINE_MONITOR_LOG_EN
`ifndef logI
`define logI(msg) $display("[INFO] %s", msg)
`endif
    string line_str;

    // Observes pushes and counter events only; never feeds back into the design.
    always @(posedge clk) begin
        if (resetn && push_s) begin
            line_str = $sformatf("%s%c", line_str, frm_data_s);
            if (last_s) begin
                `logI($sformatf("%m: %s", line_str));
                line_str = "";
            end
        end
        if (resetn && frm_vld_s && frm_ferr_s) `logI($sformatf("%m: framing error count %0d", ferr_cnt_d));
        if (resetn && frm_vld_s && frm_perr_s) `logI($sformatf("%m: parity error count %0d", perr_cnt_d));
        if (resetn && drop_s) `logI($sformatf("%m: overflow count %0d", ovf_cnt_d));
    end
`else
    // Synthesizable build: no line logging.
`endif

endmodule
